// File: rtl/adc_pkg.sv
// Shared types and constants for the ADS7883 sample-rate scheduler.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_WAIT = 2'd2
  } adc_state_e;

  // The ADS7883 emits one leading zero before the MSB of every conversion.
  localparam int ADC_LEAD_BITS = 1;
  // Minimum chip-select high time between conversions, in clocks.
  localparam int ADC_MIN_GAP   = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_scheduler_if.sv
// Sample port between the ADC scheduler and the frame buffer.
interface adc_scheduler_if #(
  parameter int WIDTH = 12,
  parameter int IW    = 6
);
  // sample/sample_index are stable while sample_valid is high; a transfer happens
  // on any clock edge where sample_valid and sample_ready are both high.
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;
  logic [IW-1:0]    sample_index;

  modport master (
    output sample,
    output sample_valid,
    output sample_index,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  sample_index,
    output sample_ready
  );
endinterface

// File: rtl/adc_deserializer.sv
// Bit counter and MSB-first shift register for one ADC conversion frame.
module adc_deserializer
  import adc_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             adc_sd,
  output logic             last_bit,
  output logic [WIDTH-1:0] word
);

  localparam int CW = $clog2(WIDTH + ADC_LEAD_BITS);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + ADC_LEAD_BITS - 1);
  localparam logic [CW-1:0] LEAD = CW'(ADC_LEAD_BITS);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;

  assign last_bit = enable && (cnt_q == LAST);
  // Includes the bit on the pins now, so the final LSB is in the word on last_bit.
  assign word     = {shift_q[WIDTH-2:0], adc_sd};

  always_comb begin
    cnt_d   = '0;
    shift_d = shift_q;
    if (enable) begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      if (cnt_q >= LEAD) shift_d = word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/adc_scheduler.sv
// Burst scheduler for the ADS7883: paces conversions, drives chip select and
// hands each captured sample to the frame buffer over a valid/ready port.
module adc_scheduler
  import adc_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int DIVIDER   = 32,
  parameter int FRAME_LEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  output logic            busy,
  output logic            done,
  output logic            adc_cs,
  output logic            adc_run,
  input  logic            adc_sd,
  output logic            overrun,
  output adc_state_e      dbg_state,
  adc_scheduler_if.master bus
);

  localparam int IW = idx_width(FRAME_LEN);
  localparam int PW = $clog2(DIVIDER);

  if (DIVIDER < WIDTH + 1 + ADC_MIN_GAP) begin : g_bad_divider
    $error("adc_scheduler: DIVIDER too small for WIDTH");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("adc_scheduler: FRAME_LEN must be at least 1");
  end

  adc_state_e       state_q, state_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    period_q, period_d;
  logic [IW-1:0]    burst_q, burst_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    index_q, index_d;
  logic             overrun_q, overrun_d;

  logic             last_bit;
  logic [WIDTH-1:0] word;

  adc_deserializer #(.WIDTH(WIDTH)) u_deser (
    .clk      (clk),
    .reset    (reset),
    .enable   (state_q == ST_CONV),
    .adc_sd   (adc_sd),
    .last_bit (last_bit),
    .word     (word)
  );

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    period_d  = period_q;
    burst_d   = burst_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    index_d   = index_q;
    overrun_d = overrun_q;

    if (valid_q && bus.sample_ready) valid_d = 1'b0;
    if (state_q != ST_IDLE) period_d = period_q + 1'b1;

    // stop aborts in any state; a pending sample stays on the port.
    if (stop) begin
      state_d  = ST_IDLE;
      cs_d     = 1'b1;
      busy_d   = 1'b0;
      period_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_CONV;
            cs_d      = 1'b0;
            busy_d    = 1'b1;
            period_d  = '0;
            burst_d   = '0;
            overrun_d = 1'b0;
          end
        end
        ST_CONV: begin
          if (last_bit) begin
            cs_d     = 1'b1;
            sample_d = word;
            index_d  = burst_q;
            valid_d  = 1'b1;
            if (valid_q && !bus.sample_ready) overrun_d = 1'b1;
            if (burst_q == IW'(FRAME_LEN - 1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (period_q == PW'(DIVIDER - 1)) begin
            period_d = '0;
            burst_d  = burst_q + 1'b1;
            cs_d     = 1'b0;
            state_d  = ST_CONV;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= '0;
      burst_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      period_q  <= period_d;
      burst_q   <= burst_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy             = busy_q;
  assign adc_run          = busy_q;
  assign done             = done_q;
  assign adc_cs           = cs_q;
  assign overrun          = overrun_q;
  assign dbg_state        = state_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_index = index_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// Self-checking bench for adc_scheduler with a negedge-shifting ADS7883 model.
module tb_adc_scheduler;
  import adc_pkg::*;

  localparam int WIDTH     = 12;
  localparam int DIVIDER   = 16;
  localparam int FRAME_LEN = 4;
  localparam int IW        = idx_width(FRAME_LEN);
  localparam int SW        = IW + WIDTH;
  localparam int NV        = 8;

  typedef struct {
    logic [WIDTH-1:0] pat;
    bit               rnd;
    int               mode;          // 0 ready=1, 1 ready=0, 2 ready only in load cycles, 3 manual
    int               restart_off;   // >0: extra start pulse sampled at P0+restart_off
    bit               chain;         // next burst started the cycle after busy falls
    bit               exp_ovr;
    bit               exp_valid_end;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start, stop, adc_sd;
  logic busy, done, adc_cs, adc_run, overrun;
  adc_state_e dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_scheduler_if #(.WIDTH(WIDTH), .IW(IW)) bus ();

  adc_scheduler #(.WIDTH(WIDTH), .DIVIDER(DIVIDER), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .adc_cs    (adc_cs),
    .adc_run   (adc_run),
    .adc_sd    (adc_sd),
    .overrun   (overrun),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] exp_q[$];
  int            fall_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            p0 = 0;
  int            ready_mode = 0;
  int            model_idx = 0;
  int            adc_bit = 0;
  logic [WIDTH-1:0] base_pat = '0;
  logic [WIDTH-1:0] cur_pat = '0;
  bit            rand_pat = 1'b0;
  logic          prev_cs = 1'b1;
  logic [SW-1:0] e;
  vec_t          vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model: leading zero, then MSB..LSB on negedges ----------------
  always @(negedge clk) begin
    if (adc_cs !== 1'b0) begin
      adc_bit = 0;
      adc_sd  = 1'b0;
    end else begin
      if (adc_bit == 0) begin
        cur_pat = rand_pat ? WIDTH'($urandom_range(0, (1 << WIDTH) - 1)) : base_pat;
        exp_q.push_back({IW'(model_idx), cur_pat});
        fall_q.push_back(cyc);
        model_idx++;
        adc_sd = 1'b0;
      end else if (adc_bit <= WIDTH) begin
        adc_sd = cur_pat[WIDTH-adc_bit];
      end else begin
        adc_sd = 1'b0;
      end
      adc_bit++;
    end
  end

  // ---------------- ready driver ----------------
  always @(negedge clk) begin
    case (ready_mode)
      0: bus.sample_ready = 1'b1;
      1: bus.sample_ready = 1'b0;
      2: bus.sample_ready = (cyc >= p0) && (((cyc - p0) % DIVIDER) == WIDTH);
      default: ;
    endcase
  end

  // ---------------- monitor: every load is a chip-select rise that is not an abort ----------------
  always @(negedge clk) begin
    if (prev_cs === 1'b0 && adc_cs === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected sample: got %0h index %0d, none expected", bus.sample, bus.sample_index);
      end else begin
        e = exp_q.pop_front();
        check("sample value", 32'(bus.sample), 32'(e[WIDTH-1:0]));
        check("sample index", 32'(bus.sample_index), 32'(e[SW-1:WIDTH]));
        check("valid on load", 32'(bus.sample_valid), 32'd1);
      end
    end
    prev_cs = adc_cs;
  end

  // ---------------- driver tasks ----------------
  task automatic start_burst(input vec_t v);
    @(negedge clk);
    base_pat   = v.pat;
    rand_pat   = v.rnd;
    ready_mode = v.mode;
    model_idx  = 0;
    fall_q.delete();
    start = 1'b1;
    p0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_burst(input vec_t v, input bit chain, input vec_t nv);
    bit got_done = 1'b0;
    for (int i = 0; i < 4 * DIVIDER * FRAME_LEN && !got_done; i++) begin
      @(negedge clk);
      start = (v.restart_off > 0) && (cyc == p0 + v.restart_off - 1);
      if (done === 1'b1) got_done = 1'b1;
    end
    start = 1'b0;
    check("done seen", 32'(got_done), 32'd1);
    check("done cycle", 32'(cyc - p0), 32'((FRAME_LEN - 1) * DIVIDER + WIDTH + 1));
    check("busy at done", 32'(busy), 32'd0);
    check("adc_run at done", 32'(adc_run), 32'd0);
    check("cs at done", 32'(adc_cs), 32'd1);
    check("last index", 32'(bus.sample_index), 32'(FRAME_LEN - 1));
    check("overrun", 32'(overrun), 32'(v.exp_ovr));
    check("valid at done", 32'(bus.sample_valid), 32'd1);
    check("state at done", 32'(dbg_state), 32'(ST_IDLE));
    check("cs fall count", 32'(fall_q.size()), 32'(FRAME_LEN));
    for (int k = 0; k < fall_q.size() && k < FRAME_LEN; k++)
      check("cs fall cycle", 32'(fall_q[k] - p0), 32'(k * DIVIDER));
    if (chain) begin
      base_pat   = nv.pat;
      rand_pat   = nv.rnd;
      ready_mode = nv.mode;
      model_idx  = 0;
      fall_q.delete();
      start = 1'b1;
      p0    = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      check("restart busy", 32'(busy), 32'd1);
      check("restart cs", 32'(adc_cs), 32'd0);
    end else begin
      @(negedge clk);
      check("done pulse width", 32'(done), 32'd0);
      check("queue drained", 32'(exp_q.size()), 32'd0);
      check("valid after done", 32'(bus.sample_valid), 32'(v.exp_valid_end));
      if (v.exp_valid_end) begin
        ready_mode       = 3;
        bus.sample_ready = 1'b1;
        @(negedge clk);
        check("final accept", 32'(bus.sample_valid), 32'd0);
        bus.sample_ready = 1'b0;
      end
    end
  endtask

  task automatic abort_at(input int off, input int mode, input bit exp_valid,
                          input logic [WIDTH-1:0] exp_sample);
    vec_t v;
    bit saw_done = 1'b0;
    v = '{12'h5A3, 1'b0, mode, 0, 1'b0, 1'b0, 1'b0};
    start_burst(v);
    repeat (off) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_q.delete();
    check("abort cs", 32'(adc_cs), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort adc_run", 32'(adc_run), 32'd0);
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 2 * DIVIDER; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || adc_cs === 1'b0) saw_done = 1'b1;
    end
    check("abort quiet", 32'(saw_done), 32'd0);
    check("abort valid kept", 32'(bus.sample_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("abort sample kept", 32'(bus.sample), 32'(exp_sample));
      check("abort index kept", 32'(bus.sample_index), 32'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cs"}, 32'(adc_cs), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " adc_run"}, 32'(adc_run), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " valid"}, 32'(bus.sample_valid), 32'd0);
    check({tag, " overrun"}, 32'(overrun), 32'd0);
    check({tag, " sample"}, 32'(bus.sample), 32'd0);
    check({tag, " index"}, 32'(bus.sample_index), 32'd0);
    check({tag, " state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    bit prev_chain = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;

    vecs[0] = '{12'hA5C, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};  // single burst
    vecs[1] = '{12'h800, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};  // MSB alignment
    vecs[2] = '{12'h001, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};  // LSB alignment
    vecs[3] = '{12'h000, 1'b1, 0, 20, 1'b0, 1'b0, 1'b0};  // random words, start while busy
    vecs[4] = '{12'hA5C, 1'b0, 1, 0,  1'b0, 1'b1, 1'b1};  // backpressure
    vecs[5] = '{12'h3C3, 1'b0, 2, 0,  1'b0, 1'b0, 1'b1};  // accept in every load cycle
    vecs[6] = '{12'hFFF, 1'b0, 0, 0,  1'b1, 1'b0, 1'b0};  // back-to-back with next
    vecs[7] = '{12'h555, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (!prev_chain) start_burst(vecs[i]);
      finish_burst(vecs[i], vecs[i].chain, vecs[(i + 1 < NV) ? i + 1 : i]);
      prev_chain = vecs[i].chain;
    end

    abort_at(5, 0, 1'b0, 12'h000);
    abort_at(DIVIDER + 5, 1, 1'b1, 12'h5A3);

    // start and stop together from idle
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start+stop busy", 32'(busy), 32'd0);
    check("start+stop state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("start+stop cs", 32'(adc_cs), 32'd1);
    end

    // reset in the middle of the second conversion; sample 0 overwrites the held one
    rv = '{12'h9E1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
    start_burst(rv);
    repeat (20) @(negedge clk);
    check("pre-reset overrun", 32'(overrun), 32'd1);
    check("pre-reset cs", 32'(adc_cs), 32'd0);
    #2 reset = 1'b1;
    #1 check_reset("async reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();

    rv = '{12'h6B2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    start_burst(rv);
    finish_burst(rv, 1'b0, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
